branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 110 +++++++++++
 tb/tb_branch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Branch resolution unit: compares operands, computes the next PC, flags
// mispredicts, illegal opcodes and misaligned targets, and keeps saturating
// branch/mispredict statistics. One-deep result register, valid/ready on both sides.
module branch_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   input  logic             pred_taken,
   input  logic             flush,
   input  logic             clr_cnt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             taken,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             mispredict,
   output logic             illegal,
   output logic             misalign,
   output logic [CNT_W-1:0] cnt_branch,
   output logic [CNT_W-1:0] cnt_mispred
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic            eq_c;
   logic            lt_s_c;
   logic            lt_u_c;
   logic            legal_c;
   logic            cond_c;
   logic            taken_c;
   logic            mis_c;
   logic            mal_c;
   logic            accept_c;
   logic [XLEN-1:0] target_c;
   logic [XLEN-1:0] seq_c;
   logic [XLEN-1:0] redir_c;

   assign eq_c     = (rs1 == rs2);
   assign lt_s_c   = ($signed(rs1) < $signed(rs2));
   assign lt_u_c   = (rs1 < rs2);
   assign target_c = pc + imm;
   assign seq_c    = pc + XLEN'(4);

   // Decode funct3 into a branch condition; 010/011 are illegal.
   always_comb begin
      legal_c = 1'b1;
      cond_c  = 1'b0;
      case (funct3)
         3'b000:  cond_c = eq_c;
         3'b001:  cond_c = ~eq_c;
         3'b100:  cond_c = lt_s_c;
         3'b101:  cond_c = ~lt_s_c;
         3'b110:  cond_c = lt_u_c;
         3'b111:  cond_c = ~lt_u_c;
         default: legal_c = 1'b0;
      endcase
   end

   assign taken_c = legal_c & cond_c;
   assign redir_c = taken_c ? target_c : seq_c;
   assign mis_c   = legal_c & (taken_c ^ pred_taken);
   assign mal_c   = taken_c & (target_c[1:0] != 2'b00);

   // Accept only out of reset, without flush, and when the result slot frees up.
   assign in_ready = rst_n & ~flush & (~out_valid | out_ready);
   assign accept_c = in_valid & in_ready;

   // Result register: load on accept, drop on handshake or flush, hold otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         taken       <= 1'b0;
         redirect_pc <= '0;
         mispredict  <= 1'b0;
         illegal     <= 1'b0;
         misalign    <= 1'b0;
      end else if (accept_c) begin
         out_valid   <= 1'b1;
         taken       <= taken_c;
         redirect_pc <= redir_c;
         mispredict  <= mis_c;
         illegal     <= ~legal_c;
         misalign    <= mal_c;
      end else if (flush || (out_valid && out_ready)) begin
         out_valid   <= 1'b0;
      end
   end

   // Saturating statistics; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n || clr_cnt) begin
         cnt_branch  <= '0;
         cnt_mispred <= '0;
      end else if (accept_c) begin
         if (legal_c && (cnt_branch != CNT_MAX))
            cnt_branch <= cnt_branch + CNT_W'(1);
         if (mis_c && (cnt_mispred != CNT_MAX))
            cnt_mispred <= cnt_mispred + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: stimulus pushes hand-computed results,
// a monitor pops and compares on every output handshake.
module tb_branch_unit;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] redir;
      logic            mis;
      logic            ill;
      logic            mal;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  rs1, rs2, pc, imm;
   logic             pred_taken;
   logic             flush;
   logic             clr_cnt;
   logic             out_valid;
   logic             out_ready;
   logic             taken;
   logic [XLEN-1:0]  redirect_pc;
   logic             mispredict;
   logic             illegal;
   logic             misalign;
   logic [CNT_W-1:0] cnt_branch;
   logic [CNT_W-1:0] cnt_mispred;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
      .pred_taken(pred_taken), .flush(flush), .clr_cnt(clr_cnt),
      .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
      .redirect_pc(redirect_pc), .mispredict(mispredict), .illegal(illegal),
      .misalign(misalign), .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_cnt(input string name, input int b, input int m);
      chk({name, ".cnt_branch"}, 64'(cnt_branch), 64'(b));
      chk({name, ".cnt_mispred"}, 64'(cnt_mispred), 64'(m));
   endtask

   // Present one request, wait (bounded) for acceptance, push its expected result.
   task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] p, input logic [XLEN-1:0] i, input logic pt,
                        input logic e_tk, input logic [XLEN-1:0] e_rd, input logic e_mis,
                        input logic e_ill, input logic e_mal);
      exp_t e;
      int   waited;
      funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pt;
      in_valid = 1'b1;
      #1;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("issue_timeout", 64'(in_ready), 64'(1));
         in_valid = 1'b0;
         return;
      end
      e.taken = e_tk; e.redir = e_rd; e.mis = e_mis; e.ill = e_ill; e.mal = e_mal;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare on handshake, discard a result killed by flush.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 64'(out_valid), 64'(0));
            end else begin
               e = sb.pop_front();
               chk("res.taken", 64'(taken), 64'(e.taken));
               chk("res.redirect_pc", 64'(redirect_pc), 64'(e.redir));
               chk("res.mispredict", 64'(mispredict), 64'(e.mis));
               chk("res.illegal", 64'(illegal), 64'(e.ill));
               chk("res.misalign", 64'(misalign), 64'(e.mal));
            end
         end else if (rst_n === 1'b1 && out_valid === 1'b1 && flush === 1'b1 && sb.size() > 0) begin
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
      pred_taken = 1'b0; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.in_ready", 64'(in_ready), 64'(0));
      chk("rst.out_valid", 64'(out_valid), 64'(0));
      chk("rst.redirect_pc", 64'(redirect_pc), 64'(0));
      chk_cnt("rst", 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // bge equal signed min, predicted not-taken
      issue(3'b101, 32'h8000_0000, 32'h8000_0000, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
      chk_cnt("bge", 1, 1);
      // illegal funct3
      issue(3'b010, 32'h1, 32'h1, 32'h300, 32'h40, 1'b1, 1'b0, 32'h304, 1'b0, 1'b1, 1'b0);
      chk_cnt("illegal", 1, 1);
      // blt / bltu with -1 vs 1
      issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1, 1'b1, 32'h240, 1'b0, 1'b0, 1'b0);
      chk_cnt("blt", 2, 1);
      issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1, 1'b0, 32'h204, 1'b1, 1'b0, 1'b0);
      chk_cnt("bltu", 3, 2);
      // beq taken to misaligned target
      issue(3'b000, 32'h5, 32'h5, 32'h0, 32'h6, 1'b1, 1'b1, 32'h6, 1'b0, 1'b0, 1'b1);
      chk_cnt("sat", 3, 2);
      // bne with negative offset, bgeu not-taken wrapping pc+4, bge target wrap, bge negative
      issue(3'b001, 32'h1, 32'h2, 32'h1000, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'hFF0, 1'b0, 1'b0, 1'b0);
      issue(3'b111, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      issue(3'b101, 32'h1, 32'h0, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      issue(3'b101, 32'hFFFF_FFFE, 32'h1, 32'h40, 32'h8, 1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0);

      // clear, then five back-to-back mispredicts saturate both counters
      clr_cnt = 1'b1;
      idle();
      clr_cnt = 1'b0;
      chk_cnt("clr", 0, 0);
      for (int k = 0; k < 5; k++) begin
         issue(3'b000, 32'h1, 32'h2, 32'h10, 32'h8, 1'b1, 1'b0, 32'h14, 1'b1, 1'b0, 1'b0);
         chk("b2b.out_valid", 64'(out_valid), 64'(1));
         chk_cnt("b2b", (k < 3) ? k + 1 : 3, (k < 3) ? k + 1 : 3);
      end
      // clear beats same-cycle increment
      clr_cnt = 1'b1;
      issue(3'b000, 32'h1, 32'h2, 32'h10, 32'h8, 1'b1, 1'b0, 32'h14, 1'b1, 1'b0, 1'b0);
      clr_cnt = 1'b0;
      chk_cnt("clr_acc", 0, 0);
      idle();

      // Backpressure: result A held 3 cycles, then handshake + accept of B together
      out_ready = 1'b0;
      issue(3'b110, 32'h1, 32'h2, 32'h500, 32'h100, 1'b1, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
      funct3 = 3'b001; rs1 = 32'h7; rs2 = 32'h7; pc = 32'h600; imm = 32'h8; pred_taken = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall.in_ready", 64'(in_ready), 64'(0));
         chk("stall.redirect_pc", 64'(redirect_pc), 64'(32'h600));
         chk("stall.taken", 64'(taken), 64'(1));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      issue(3'b001, 32'h7, 32'h7, 32'h600, 32'h8, 1'b0, 1'b0, 32'h604, 1'b0, 1'b0, 1'b0);
      chk("stall.b2b_valid", 64'(out_valid), 64'(1));
      chk_cnt("stall", 2, 0);
      idle();

      // Flush a held result while a request is offered
      out_ready = 1'b0;
      issue(3'b000, 32'h3, 32'h3, 32'h700, 32'h10, 1'b0, 1'b1, 32'h710, 1'b1, 1'b0, 1'b0);
      chk_cnt("pre_flush", 3, 1);
      flush = 1'b1;
      in_valid = 1'b1;
      funct3 = 3'b000; rs1 = 32'h1; rs2 = 32'h2; pred_taken = 1'b1;
      @(negedge clk);
      chk("flush.in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush.out_valid", 64'(out_valid), 64'(0));
      chk_cnt("flush", 3, 1);

      // Reset in the middle of a stall
      issue(3'b100, 32'h1, 32'h2, 32'h800, 32'h4, 1'b1, 1'b1, 32'h804, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      chk("mrst.in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      sb.delete();
      in_valid = 1'b0;
      chk("mrst.out_valid", 64'(out_valid), 64'(0));
      chk("mrst.taken", 64'(taken), 64'(0));
      chk("mrst.redirect_pc", 64'(redirect_pc), 64'(0));
      chk("mrst.flags", 64'({mispredict, illegal, misalign}), 64'(0));
      chk_cnt("mrst", 0, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // First accept right after reset release
      issue(3'b111, 32'h5, 32'h5, 32'h900, 32'hC, 1'b0, 1'b1, 32'h90C, 1'b1, 1'b0, 1'b0);
      chk_cnt("post_rst", 1, 1);
      repeat (3) idle();
      chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
